// File: rtl/tea_dispatch_scheduler.sv
// Dispatch scheduler for a pool of TEA decryptor engines.
// Blocks are handed to engines round-robin and retired strictly in the
// order they were accepted, even when engines finish out of order.
module tea_dispatch_scheduler #(
    parameter int NUM_ENG = 8,
    parameter int CNT_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_block,
    output logic [NUM_ENG-1:0]     eng_start,
    output logic [63:0]            eng_block,
    output logic                   eng_abort,
    input  logic [NUM_ENG-1:0]     eng_done,
    input  logic [64*NUM_ENG-1:0]  eng_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_block,
    output logic [CNT_W-1:0]       occupancy,
    output logic                   err
);

    localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ENG - 1);
    localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(NUM_ENG);

    logic [NUM_ENG-1:0][1:0] state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        occupancy_q, occupancy_d;
    logic                    out_valid_q, out_valid_d;
    logic [63:0]             out_block_q, out_block_d;
    logic [63:0]             eng_block_q, eng_block_d;
    logic [NUM_ENG-1:0]      eng_start_q, eng_start_d;
    logic                    eng_abort_q, eng_abort_d;
    logic                    err_q, err_d;

    logic                    in_ready_s;
    logic                    accept_s;
    logic                    retire_s;
    logic [63:0]             rd_result_s;

    // Wrap a pool pointer back to engine 0 after the last engine.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Handshake qualifiers; everything here looks only at registered state,
    // so a retire cannot free the engine that is being dispatched to.
    always_comb begin
        in_ready_s  = ena & ~flush & (state_q[wr_ptr_q] == ST_IDLE) &
                      (occupancy_q != OCC_FULL);
        accept_s    = in_valid & in_ready_s;
        retire_s    = ena & ~flush & (state_q[rd_ptr_q] == ST_DONE) &
                      (~out_valid_q | out_ready);
        rd_result_s = eng_result[64*int'(rd_ptr_q) +: 64];
    end

    // Next-state computation for engine states, pointers, and output registers.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occupancy_d = occupancy_q;
        out_valid_d = out_valid_q;
        out_block_d = out_block_q;
        eng_block_d = eng_block_q;
        eng_start_d = '0;
        eng_abort_d = 1'b0;
        err_d       = err_q;
        if (flush) begin
            // Abort everything in flight; completions in this cycle are dropped.
            for (int i = 0; i < NUM_ENG; i++) begin
                state_d[i] = ST_IDLE;
            end
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occupancy_d = '0;
            out_valid_d = 1'b0;
            eng_abort_d = 1'b1;
        end else if (ena) begin
            // A completion is only legitimate for an engine that is running.
            for (int i = 0; i < NUM_ENG; i++) begin
                if (eng_done[i]) begin
                    if (state_q[i] == ST_RUN) begin
                        state_d[i] = ST_DONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d[i] = state_d[i];
                end
            end
            if (retire_s) begin
                state_d[rd_ptr_q] = ST_IDLE;
                out_block_d       = rd_result_s;
                out_valid_d       = 1'b1;
                rd_ptr_d          = next_ptr(rd_ptr_q);
            end else if (out_valid_q & out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (accept_s) begin
                state_d[wr_ptr_q]     = ST_RUN;
                eng_block_d           = in_block;
                eng_start_d[wr_ptr_q] = 1'b1;
                wr_ptr_d              = next_ptr(wr_ptr_q);
            end else begin
                eng_start_d = '0;
            end
            case ({accept_s, retire_s})
                2'b10:   occupancy_d = occupancy_q + CNT_W'(1);
                2'b01:   occupancy_d = occupancy_q - CNT_W'(1);
                default: occupancy_d = occupancy_q;
            endcase
        end else begin
            // Disabled: hold all state and keep the engine strobes quiet.
            eng_start_d = '0;
            eng_abort_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occupancy_q <= '0;
            out_valid_q <= 1'b0;
            out_block_q <= 64'h0;
            eng_block_q <= 64'h0;
            eng_start_q <= '0;
            eng_abort_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occupancy_q <= occupancy_d;
            out_valid_q <= out_valid_d;
            out_block_q <= out_block_d;
            eng_block_q <= eng_block_d;
            eng_start_q <= eng_start_d;
            eng_abort_q <= eng_abort_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign eng_start = eng_start_q;
    assign eng_block = eng_block_q;
    assign eng_abort = eng_abort_q;
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;
    assign occupancy = occupancy_q;
    assign err       = err_q;

endmodule

// File: doc/tea_dispatch_scheduler.md
TEA_DISPATCH_SCHEDULER -- requirements
Module: tea_dispatch_scheduler

Interface
REQ-001 Parameter NUM_ENG, default 8, number of decryptor engines scheduled; legal values 2..16.
REQ-002 Parameter CNT_W, default 5, width of occupancy count; SHALL satisfy 2^CNT_W > NUM_ENG.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ena  in  1  global enable; when low no state changes and eng_start stays low.
REQ-006 flush  in  1  synchronous abort of all in-flight work.
REQ-007 in_valid  in  1  input block offered.
REQ-008 in_ready  out  1  scheduler accepts block this cycle.
REQ-009 in_block  in  64  ciphertext block.
REQ-010 eng_start  out  NUM_ENG  one-hot single-cycle start pulse per engine.
REQ-011 eng_block  out  64  registered block for the started engine.
REQ-012 eng_abort  out  1  one-cycle pulse to all engines on flush.
REQ-013 eng_done  in  NUM_ENG  per-engine completion pulse.
REQ-014 eng_result  in  64*NUM_ENG  flattened results; engine i at bits [64*i+63:64*i], stable from done until next start.
REQ-015 out_valid  out  1  output block valid.
REQ-016 out_ready  in  1  downstream accepts output.
REQ-017 out_block  out  64  plaintext block, in input order.
REQ-018 occupancy  out  CNT_W  engines in RUN or DONE.
REQ-019 err  out  1  sticky protocol-error flag.

Function
REQ-020 Per-engine state SHALL be one of IDLE, RUN, DONE.
REQ-021 Dispatch pointer wr_ptr and retire pointer rd_ptr SHALL each count 0..NUM_ENG-1 and wrap to 0 after NUM_ENG-1.
REQ-022 in_ready SHALL equal ena & ~flush & (state[wr_ptr]==IDLE), driven from registered state only.
REQ-023 On in_valid & in_ready: eng_block <= in_block, eng_start[wr_ptr] pulses high the next cycle for exactly one cycle, state[wr_ptr] <= RUN, wr_ptr advances.
REQ-024 eng_done[i] with state[i]==RUN SHALL set state[i] <= DONE.
REQ-025 eng_done[i] with state[i] != RUN SHALL be ignored for state and SHALL set err.
REQ-026 Retire condition: ena & state[rd_ptr]==DONE & (~out_valid | out_ready); then out_block <= result of engine rd_ptr, out_valid <= 1, state[rd_ptr] <= IDLE, rd_ptr advances.
REQ-027 out_valid & ~out_ready SHALL hold out_block and out_valid unchanged.
REQ-028 out_valid & out_ready with no retire SHALL clear out_valid.
REQ-029 Outputs SHALL leave strictly in acceptance order regardless of engine completion order.
REQ-030 Retire freeing engine k and dispatch to engine k in the same cycle SHALL NOT occur; dispatch sees the freed engine the following cycle.
REQ-031 occupancy SHALL increment on dispatch, decrement on retire, stay unchanged when both occur in one cycle.
REQ-032 Full condition: occupancy==NUM_ENG forces in_ready low.
REQ-033 Latency: accept at cycle t gives eng_start at t+1; done at cycle d with empty output and engine at rd_ptr gives out_valid at d+2.
REQ-034 flush (ena-independent) SHALL next cycle: all states IDLE, pointers 0, occupancy 0, out_valid 0, eng_start 0, eng_abort pulse high one cycle; err unchanged.
REQ-035 flush coincident with in_valid SHALL drop the block (in_ready low).
REQ-036 eng_done arriving in the flush cycle SHALL be discarded without setting err.

Reset
REQ-037 rst_n low SHALL immediately set: states IDLE, wr_ptr 0, rd_ptr 0, occupancy 0, out_valid 0, out_block 0, eng_block 0, eng_start 0, eng_abort 0, err 0.
REQ-038 Reset asserted mid-operation SHALL discard in-flight work without eng_abort; engines are reset by the same rst_n.
REQ-039 First dispatch after rst_n deasserts SHALL target engine 0.

Verification
REQ-040 Single block: in_block=64'h0123_4567_89AB_CDEF accepted cycle 1, eng_done[0] cycle 10 -> eng_start=8'h01 cycle 2, out_valid cycle 12, out_block = engine 0 result.
REQ-041 Reordering: 3 blocks to engines 0,1,2; done order 2,0,1 -> outputs in order 0,1,2; occupancy peaks 3, ends 0.
REQ-042 Full/backpressure: 9 blocks, no done, out_ready=0 -> in_ready low after 8 accepts, occupancy=8; releasing dones and out_ready drains all 8 in order, 9th then goes to engine 0.
REQ-043 Wrap: 20 blocks streamed with 4-cycle done latency, out_ready=1 -> wr_ptr/rd_ptr wrap twice, 20 outputs in order, err=0.
REQ-044 Flush mid-run: 5 in flight, flush one cycle -> eng_abort pulse, occupancy 0, out_valid 0, next accept to engine 0.
REQ-045 Spurious done: eng_done[3] while engine 3 IDLE -> err=1 and stays 1 until rst_n; state unchanged.
